multicycle_control_fsm: RTL and testbench

Moore-style sequencing FSM for the multi-cycle MIPS datapath; it replaces the ad-hoc controller and drives every mux select, write enable and ALU operation code of the PC, shared instruction/data memory, instruction register, register file and ALU. It decodes OpCode/Funct once per instruction in the decode state and walks the fetch → decode → execute → memory → writeback sequence with a per-class cycle count of 3–5. It sits beside the datapath top level, fed only by the instruction register fields; the ALU Zero flag is consumed in the datapath, not here.

---
 rtl/multicycle_ctrl_pkg.sv | 91 +++++++++
 rtl/multicycle_control_fsm_inst_class_decode.sv | 31 +++
 rtl/multicycle_control_fsm.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states,
// instruction classes, opcode/Funct values, datapath mux select codes,
// ALU operation codes and the bundle of control outputs.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IF      = 4'd0,
    ST_ID      = 4'd1,
    ST_MEM_ADR = 4'd2,
    ST_MEM_RD  = 4'd3,
    ST_MEM_WB  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_EX_R    = 4'd6,
    ST_EX_I    = 4'd7,
    ST_ALU_WB  = 4'd8,
    ST_BR      = 4'd9,
    ST_JMP     = 4'd10
  } state_e;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_STORE, CLS_RTYPE, CLS_ITYPE, CLS_BRANCH,
    CLS_J, CLS_JAL, CLS_JR, CLS_JALR, CLS_ILLEGAL
  } inst_class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_MDR    = 2'b00;
  localparam logic [1:0] M2R_ALUOUT = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REGA  = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_SUB   = 4'b0001;
  localparam logic [3:0] ALUOP_RTYPE = 4'b0010;
  localparam logic [3:0] ALUOP_AND   = 4'b0011;
  localparam logic [3:0] ALUOP_SLT   = 4'b0100;
  localparam logic [3:0] ALUOP_SLTU  = 4'b0101;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       ext_op;
    logic       lui_op;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_inst_class_decode.sv
// Combinational instruction classifier.
// Ports: op_code/funct (IR fields) in, inst_class out.
module inst_class_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0]  op_code,
  input  logic [5:0]  funct,
  output inst_class_e inst_class
);

  always_comb begin
    inst_class = CLS_ILLEGAL;
    case (op_code)
      OP_LW:    inst_class = CLS_LOAD;
      OP_SW:    inst_class = CLS_STORE;
      OP_BEQ:   inst_class = CLS_BRANCH;
      OP_J:     inst_class = CLS_J;
      OP_JAL:   inst_class = CLS_JAL;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI:
                inst_class = CLS_ITYPE;
      // jr/jalr share the R-type opcode but sequence as jumps
      OP_RTYPE: begin
        if (funct == FN_JR)        inst_class = CLS_JR;
        else if (funct == FN_JALR) inst_class = CLS_JALR;
        else                       inst_class = CLS_RTYPE;
      end
      default:  inst_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencing controller for the multi-cycle MIPS datapath.
// Ports: clk, reset (async, active-low), OpCode/Funct from the IR;
// datapath enables/selects, ALUOp, illegal_inst pulse, debug state.
// Control outputs are registered one cycle ahead (computed from the next
// state) so they are clean for the whole state; reset gates them to 0.
module multicycle_control_fsm
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] PCSrc,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic       illegal_inst,
  output logic [3:0] state
);

  inst_class_e dec_class, cls_q, cls_next;
  state_e      state_q, state_next;
  ctrl_t       ctrl_q, ctrl_out;

  inst_class_decode u_decode (
    .op_code    (OpCode),
    .funct      (Funct),
    .inst_class (dec_class)
  );

  // Control word for a state. op/fn only matter for EX_R/EX_I, which are
  // entered solely from ID, so the IR fields are still the decoded ones.
  function automatic ctrl_t ctrl_for(state_e s, inst_class_e c,
                                     logic [5:0] op, logic [5:0] fn);
    ctrl_t k;
    k = '0;
    case (s)
      ST_IF: begin
        k.mem_read  = 1'b1;
        k.ir_write  = 1'b1;
        k.pc_write  = 1'b1;
        k.alu_src_a = SRCA_PC;
        k.alu_src_b = SRCB_FOUR;
        k.alu_op    = ALUOP_ADD;
        k.pc_src    = PCSRC_ALU;
      end
      ST_ID: begin
        k.alu_src_a = SRCA_PC;
        k.alu_src_b = SRCB_IMMSH;
        k.alu_op    = ALUOP_ADD;
        k.ext_op    = 1'b1;
      end
      ST_MEM_ADR: begin
        k.alu_src_a = SRCA_REGA;
        k.alu_src_b = SRCB_IMM;
        k.ext_op    = 1'b1;
        k.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        k.i_or_d   = 1'b1;
        k.mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        k.reg_dst    = REGDST_RT;
        k.mem_to_reg = M2R_MDR;
        k.reg_write  = 1'b1;
      end
      ST_MEM_WR: begin
        k.i_or_d    = 1'b1;
        k.mem_write = 1'b1;
      end
      ST_EX_R: begin
        k.alu_src_a = (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA)
                      ? SRCA_SHAMT : SRCA_REGA;
        k.alu_src_b = SRCB_REGB;
        k.alu_op    = ALUOP_RTYPE;
      end
      ST_EX_I: begin
        k.alu_src_a = SRCA_REGA;
        k.alu_src_b = SRCB_IMM;
        k.ext_op    = (op != OP_ANDI);
        k.lui_op    = (op == OP_LUI);
        case (op)
          OP_ANDI:  k.alu_op = ALUOP_AND;
          OP_SLTI:  k.alu_op = ALUOP_SLT;
          OP_SLTIU: k.alu_op = ALUOP_SLTU;
          default:  k.alu_op = ALUOP_ADD;
        endcase
      end
      ST_ALU_WB: begin
        k.mem_to_reg = M2R_ALUOUT;
        k.reg_write  = 1'b1;
        k.reg_dst    = (c == CLS_RTYPE) ? REGDST_RD : REGDST_RT;
      end
      ST_BR: begin
        k.alu_src_a     = SRCA_REGA;
        k.alu_src_b     = SRCB_REGB;
        k.alu_op        = ALUOP_SUB;
        k.pc_write_cond = 1'b1;
        k.pc_src        = PCSRC_ALUOUT;
      end
      ST_JMP: begin
        k.pc_write = 1'b1;
        k.pc_src   = (c == CLS_JR || c == CLS_JALR) ? PCSRC_REGA : PCSRC_JUMP;
        // Link writes PC, which already holds PC+4 from IF
        if (c == CLS_JAL) begin
          k.reg_dst    = REGDST_RA;
          k.mem_to_reg = M2R_PC;
          k.reg_write  = 1'b1;
        end else if (c == CLS_JALR) begin
          k.reg_dst    = REGDST_RD;
          k.mem_to_reg = M2R_PC;
          k.reg_write  = 1'b1;
        end
      end
      default: k = '0;
    endcase
    return k;
  endfunction

  always_comb begin
    state_next = ST_IF;
    cls_next   = cls_q;
    case (state_q)
      ST_IF: state_next = ST_ID;
      ST_ID: begin
        cls_next = dec_class;
        case (dec_class)
          CLS_LOAD, CLS_STORE:                  state_next = ST_MEM_ADR;
          CLS_RTYPE:                            state_next = ST_EX_R;
          CLS_ITYPE:                            state_next = ST_EX_I;
          CLS_BRANCH:                           state_next = ST_BR;
          CLS_J, CLS_JAL, CLS_JR, CLS_JALR:     state_next = ST_JMP;
          default:                              state_next = ST_IF;
        endcase
      end
      ST_MEM_ADR: state_next = (cls_q == CLS_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:  state_next = ST_MEM_WB;
      ST_EX_R,
      ST_EX_I:    state_next = ST_ALU_WB;
      default:    state_next = ST_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IF;
      cls_q   <= CLS_LOAD;
      // Preload the IF word so the first fetch is live as soon as reset lifts
      ctrl_q  <= ctrl_for(ST_IF, CLS_LOAD, 6'h00, 6'h00);
    end else begin
      state_q <= state_next;
      cls_q   <= cls_next;
      ctrl_q  <= ctrl_for(state_next, cls_next, OpCode, Funct);
    end
  end

  // Asynchronous gating guarantees no enable survives into a reset cycle
  assign ctrl_out     = reset ? ctrl_q : '0;
  assign illegal_inst = reset && (state_q == ST_ID) && (dec_class == CLS_ILLEGAL);
  assign state        = state_q;

  assign PCWrite     = ctrl_out.pc_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign IorD        = ctrl_out.i_or_d;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign IRWrite     = ctrl_out.ir_write;
  assign RegWrite    = ctrl_out.reg_write;
  assign ExtOp       = ctrl_out.ext_op;
  assign LuiOp       = ctrl_out.lui_op;
  assign PCSrc       = ctrl_out.pc_src;
  assign RegDst      = ctrl_out.reg_dst;
  assign MemtoReg    = ctrl_out.mem_to_reg;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign ALUOp       = ctrl_out.alu_op;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: a per-instruction reference
// model queues the expected per-cycle output vector; a negedge monitor pops
// and compares while reset is high.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       RegWrite, ExtOp, LuiOp, illegal_inst;
  logic [1:0] PCSrc, RegDst, MemtoReg, ALUSrcA, ALUSrcB;
  logic [3:0] ALUOp, state;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp), .PCSrc(PCSrc),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal_inst(illegal_inst),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mr, mw, irw, rw, ext, lui, ill;
    logic [1:0] pcsrc, regdst, m2r, srca, srcb;
    logic [3:0] aluop;
  } exp_t;

  typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_J, K_JAL, K_JR, K_JALR, K_BAD} kind_e;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t actual();
    exp_t a;
    a.st = state; a.pcw = PCWrite; a.pcwc = PCWriteCond; a.iord = IorD;
    a.mr = MemRead; a.mw = MemWrite; a.irw = IRWrite; a.rw = RegWrite;
    a.ext = ExtOp; a.lui = LuiOp; a.ill = illegal_inst; a.pcsrc = PCSrc;
    a.regdst = RegDst; a.m2r = MemtoReg; a.srca = ALUSrcA; a.srcb = ALUSrcB;
    a.aluop = ALUOp;
    return a;
  endfunction

  function automatic kind_e classify(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h02) return K_J;
    if (op == 6'h03) return K_JAL;
    if (op == 6'h00) return (fn == 6'h08) ? K_JR : (fn == 6'h09) ? K_JALR : K_R;
    if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F}) return K_I;
    return K_BAD;
  endfunction

  function automatic exp_t blank(int s);
    exp_t e;
    e = '0;
    e.st = s[3:0];
    return e;
  endfunction

  // Reference: the whole per-cycle output trace of one instruction.
  function automatic void model(logic [5:0] op, logic [5:0] fn);
    exp_t  e;
    kind_e k;
    k = classify(op, fn);
    e = blank(0); e.mr = 1; e.irw = 1; e.pcw = 1; e.srcb = 2'b01;
    exp_q.push_back(e);
    e = blank(1); e.srcb = 2'b11; e.ext = 1; e.ill = (k == K_BAD);
    exp_q.push_back(e);
    case (k)
      K_LW, K_SW: begin
        e = blank(2); e.srca = 2'b01; e.srcb = 2'b10; e.ext = 1;
        exp_q.push_back(e);
        if (k == K_LW) begin
          e = blank(3); e.iord = 1; e.mr = 1; exp_q.push_back(e);
          e = blank(4); e.rw = 1; exp_q.push_back(e);
        end else begin
          e = blank(5); e.iord = 1; e.mw = 1; exp_q.push_back(e);
        end
      end
      K_R, K_I: begin
        if (k == K_R) begin
          e = blank(6); e.aluop = 4'b0010;
          e.srca = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'b10 : 2'b01;
        end else begin
          e = blank(7); e.srca = 2'b01; e.srcb = 2'b10;
          e.ext = (op != 6'h0C); e.lui = (op == 6'h0F);
          e.aluop = (op == 6'h0C) ? 4'b0011 : (op == 6'h0A) ? 4'b0100 :
                    (op == 6'h0B) ? 4'b0101 : 4'b0000;
        end
        exp_q.push_back(e);
        e = blank(8); e.m2r = 2'b01; e.rw = 1; e.regdst = (k == K_R) ? 2'b01 : 2'b00;
        exp_q.push_back(e);
      end
      K_BEQ: begin
        e = blank(9); e.srca = 2'b01; e.aluop = 4'b0001; e.pcwc = 1; e.pcsrc = 2'b01;
        exp_q.push_back(e);
      end
      K_J, K_JAL, K_JR, K_JALR: begin
        e = blank(10); e.pcw = 1;
        e.pcsrc = (k == K_JR || k == K_JALR) ? 2'b11 : 2'b10;
        if (k == K_JAL)  begin e.regdst = 2'b10; e.m2r = 2'b10; e.rw = 1; end
        if (k == K_JALR) begin e.regdst = 2'b01; e.m2r = 2'b10; e.rw = 1; end
        exp_q.push_back(e);
      end
      default: ;
    endcase
  endfunction

  task automatic chk_vec(string name, exp_t a, exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic chk_int(string name, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  // Issue one instruction at #1 after a rising edge while the DUT sits in IF.
  task automatic run_inst(logic [5:0] op, logic [5:0] fn);
    int n0;
    OpCode = op;
    Funct  = fn;
    n0 = exp_q.size();
    model(op, fn);
    repeat (exp_q.size() - n0) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_vec("cycle_trace", actual(), e);
    end
  end

  initial begin
    logic [5:0] op, fn;
    logic [5:0] itab [6];
    itab = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F};
    reset  = 1'b0;
    OpCode = 6'h00;
    Funct  = 6'h00;
    repeat (3) begin
      @(negedge clk);
      chk_vec("reset_hold", actual(), blank(0));
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // directed
    run_inst(6'h23, 6'h11);  // lw
    run_inst(6'h04, 6'h00);  // beq
    run_inst(6'h2B, 6'h00);  // sw
    run_inst(6'h03, 6'h00);  // jal
    run_inst(6'h00, 6'h08);  // jr
    run_inst(6'h00, 6'h00);  // sll
    run_inst(6'h0F, 6'h00);  // lui
    run_inst(6'h3F, 6'h00);  // illegal
    run_inst(6'h00, 6'h20);  // add

    // reset while in MEM_RD of a lw: queue only IF, ID, MEM_ADR
    OpCode = 6'h23; Funct = 6'h00;
    model(6'h23, 6'h00);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    repeat (3) @(posedge clk);
    #1;
    chk_int("reached_mem_rd", int'(state), 3);
    reset = 1'b0;
    #1;
    chk_vec("reset_mid_inst", actual(), blank(0));
    @(negedge clk);
    chk_vec("reset_mid_hold", actual(), blank(0));
    @(posedge clk); #1;
    reset = 1'b1;
    run_inst(6'h23, 6'h05);  // restart cleanly from IF

    // randomized
    repeat (150) begin
      fn = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 9))
        0: op = 6'h23;
        1: op = 6'h2B;
        2: op = 6'h00;
        3: op = itab[$urandom_range(0, 5)];
        4: op = 6'h04;
        5: op = 6'h02;
        6: op = 6'h03;
        7: begin op = 6'h00; fn = 6'h08 | 6'($urandom_range(0, 1)); end
        8: begin
          op = 6'h3F;
          for (int t = 0; t < 20; t++) begin
            op = 6'($urandom_range(0, 63));
            if (classify(op, fn) == K_BAD) break;
            op = 6'h3F;
          end
        end
        default: begin op = 6'h00; fn = 6'($urandom_range(0, 3)); end
      endcase
      run_inst(op, fn);
    end

    @(negedge clk);
    chk_int("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
